// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per cycle,
// fixed latency of XLEN+2 cycles from accepted start to the valid pulse.
module seq_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            kill,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   dvs_q, dvs_d;
   logic [XLEN-1:0]   dvd_q, dvd_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [1:0]        op_q, op_d;
   logic              sign_q_q, sign_q_d;
   logic              sign_r_q, sign_r_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;

   logic [XLEN:0]     shifted;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic              is_signed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         result_q <= '0;
         op_q     <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         dvd_q    <= dvd_d;
         result_q <= result_d;
         op_q     <= op_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE: if (start && !kill) state_d = CALC;
         CALC: begin
            busy = 1'b1;
            if (kill) state_d = IDLE;
            else if (cnt_q == CW'(XLEN-1)) state_d = FIX;
         end
         FIX: begin
            busy    = 1'b1;
            state_d = kill ? IDLE : DONE;
         end
         DONE: begin
            valid   = !kill;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      dvd_d    = dvd_q;
      result_d = result_q;
      op_d     = op_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      is_signed = !op[0];
      shifted  = {rem_q, quo_q[XLEN-1]};
      trial    = shifted - {1'b0, dvs_q};
      quo_fix  = sign_q_q ? -quo_q : quo_q;
      rem_fix  = sign_r_q ? -rem_q : rem_q;
      if (dz_q) begin
         quo_fix = '1;
         rem_fix = dvd_q;
      end
      // Most-negative / -1: the magnitude path already yields these, forced for clarity
      if (ovf_q) begin
         quo_fix = dvd_q;
         rem_fix = '0;
      end
      case (state_q)
         IDLE: if (start && !kill) begin
            op_d     = op;
            dvd_d    = dividend;
            dz_d     = (divisor == '0);
            ovf_d    = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
            sign_q_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            sign_r_d = is_signed && dividend[XLEN-1];
            quo_d    = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
            dvs_d    = (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
            rem_d    = '0;
            cnt_d    = '0;
         end
         CALC: begin
            if (!trial[XLEN]) begin
               rem_d = trial[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
               rem_d = shifted[XLEN-1:0];
               quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
         end
         FIX: if (!kill) result_d = op_q[1] ? rem_fix : quo_fix;
         default: ;
      endcase
   end

   assign result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboarded bench for seq_divider: driver queues expected results from an
// arithmetic reference, a negedge monitor checks valid/result/latency and busy.
module tb_seq_divider;
   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [1:0]      op = '0;
   logic [XLEN-1:0] dividend = '0;
   logic [XLEN-1:0] divisor = '0;
   logic            kill = 1'b0;
   logic            busy, valid;
   logic [XLEN-1:0] result;

   seq_divider #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
      .divisor(divisor), .kill(kill), .busy(busy), .valid(valid), .result(result)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [XLEN-1:0] res;
      int              at;
   } exp_t;
   exp_t sb[$];

   logic            act = 1'b0;
   int              act_t = 0;
   int              t_last = 0;
   logic [XLEN-1:0] last_res = '0;

   function automatic logic [XLEN-1:0] model(logic [1:0] o, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      if (b == 0) return o[1] ? a : '1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
      case (o)
         2'b00: return $signed(a) / $signed(b);
         2'b01: return a / b;
         2'b10: return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   task automatic check(string name, logic [XLEN-1:0] got, logic [XLEN-1:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
      end
   endtask

   // Monitor: busy window of the in-flight op and every valid pulse against the queue.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", {31'b0, busy},
               {31'b0, act && cyc >= act_t + 1 && cyc <= act_t + LAT - 1});
         if (valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", result, e.res);
               check("latency", cyc, e.at);
            end
         end
      end
   end

   task automatic wait_cyc(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(logic [1:0] o, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      exp_t e;
      start = 1'b1; op = o; dividend = a; divisor = b;
      t_last = cyc;
      e.res = model(o, a, b);
      e.at  = cyc + LAT;
      sb.push_back(e);
      act = 1'b1; act_t = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      op = 2'($urandom); dividend = $urandom; divisor = $urandom;
   endtask

   task automatic finish_op(logic [1:0] o, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      wait_cyc(t_last + LAT + 1);
      act = 1'b0;
      last_res = model(o, a, b);
   endtask

   task automatic run(logic [1:0] o, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
      go(o, a, b);
      finish_op(o, a, b);
   endtask

   task automatic stray();
      start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   function automatic logic [XLEN-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         4: return -$urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_valid", {31'b0, valid}, 32'd0);
      check("reset_result", result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run(2'b01, 100, 7);
      run(2'b11, 100, 7);
      run(2'b00, -7, 2);
      run(2'b10, -7, 2);
      run(2'b10, 7, -2);
      run(2'b00, 5, 0);
      run(2'b01, 5, 0);
      run(2'b10, 5, 0);
      run(2'b11, 5, 0);
      run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      run(2'b01, 32'hFFFF_FFFF, 1);

      // Starts during CALC, FIX and DONE are ignored; the next IDLE start is taken.
      begin
         int t0;
         go(2'b01, 100, 7);
         t0 = t_last;
         wait_cyc(t0 + 5);  stray();
         wait_cyc(t0 + 33); stray();
         stray();
         last_res = 14;
         run(2'b11, 100, 7);
      end

      // Flush mid-operation: no valid, result keeps the last completed value.
      begin
         int t0;
         go(2'b00, 9, 3);
         t0 = t_last;
         wait_cyc(t0 + 10);
         kill = 1'b1;
         @(posedge clk); #1;
         kill = 1'b0; act = 1'b0;
         void'(sb.pop_back());
         check("kill_busy", {31'b0, busy}, 32'd0);
         repeat (LAT + 4) begin @(posedge clk); #1; end
         check("kill_result", result, last_res);
      end

      // kill together with start in IDLE blocks acceptance.
      start = 1'b1; kill = 1'b1; op = 2'b01; dividend = 50; divisor = 5;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      check("kill_start_busy", {31'b0, busy}, 32'd0);
      repeat (LAT + 2) begin @(posedge clk); #1; end
      check("kill_start_result", result, last_res);

      for (int i = 0; i < 40; i++) run(2'($urandom), pick(), pick());

      // Asynchronous reset mid-operation clears outputs immediately.
      begin
         int t0;
         go(2'b01, 1000, 3);
         t0 = t_last;
         wait_cyc(t0 + 20);
         #2 rst = 1'b1;
         #1;
         check("arst_busy", {31'b0, busy}, 32'd0);
         check("arst_valid", {31'b0, valid}, 32'd0);
         check("arst_result", result, 32'd0);
         void'(sb.pop_back());
         act = 1'b0;
         @(posedge clk); #1;
         rst = 1'b0;
         repeat (LAT + 4) begin @(posedge clk); #1; end
         check("arst_hold", result, 32'd0);
      end

      run(2'b00, -100, 7);
      check("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
